// File: rtl/seq_ctrl_pkg.sv
// Shared types and helpers for the sequence feed controller.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Clock cycles per serial bit; ratios below one (or a zero rate) collapse to 1.
  function automatic int unsigned div_calc(input logic [27:0] clk_freq,
                                           input logic [27:0] refresh_hz);
    int unsigned d;
    if (refresh_hz == 28'd0) d = 1;
    else                     d = 32'(clk_freq / refresh_hz);
    return (d <= 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running 0..DIV-1 counter while enabled; tick marks the last count.
module tick_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_q, div_d;

  assign tick_o = en_i && (div_q == LAST);

  always_comb begin
    div_d = div_q;
    if (clr_i)      div_d = '0;
    else if (en_i)  div_d = tick_o ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) div_q <= '0;
    else          div_q <= div_d;
  end

endmodule

// File: rtl/sequence_feed_controller.sv
// Serialises a latched test pattern MSB-first into the sequence detector and
// counts detector hits over the run.
//   state | meaning
//   IDLE  | waiting for start; result outputs hold
//   SHIFT | one pattern bit presented per tick
//   DRAIN | extra ticks so late detector hits are still counted
//   DONE  | one cycle: pulse done, latch led
module sequence_feed_controller
  import seq_ctrl_pkg::*;
#(
  parameter logic [27:0] clk_freq    = 28'd1000_0000,
  parameter logic [27:0] refreshHz   = 28'd500_0000,
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned DRAIN_TICKS = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              sys_clk_in,
  input  logic              reset,
  input  logic [WORD_W-1:0] pattern_in,
  input  logic              start,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              hit_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic              led
);

  localparam int unsigned DIV = div_calc(clk_freq, refreshHz);
  localparam int unsigned IW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned DW  = (DRAIN_TICKS > 1) ? $clog2(DRAIN_TICKS) : 1;
  localparam logic [IW-1:0]    IDX_LAST = IW'(WORD_W - 1);
  localparam logic [DW-1:0]    DRN_LAST = DW'(DRAIN_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            state_q;
  logic [WORD_W-1:0] sreg_q;
  logic [IW-1:0]     idx_q;
  logic [DW-1:0]     drain_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic              hit_prev_q;
  logic              bit_out_q, bit_valid_q, busy_q, done_q, led_q;
  logic              tick, accept;

  assign accept = (state_q == ST_IDLE) && start;

  tick_divider #(.DIV(DIV)) u_div (
    .clk_i   (sys_clk_in),
    .rst_n_i (reset),
    .en_i    (busy_q),
    .clr_i   (accept),
    .tick_o  (tick)
  );

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      idx_q       <= '0;
      drain_q     <= '0;
      hit_cnt_q   <= '0;
      hit_prev_q  <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
      hit_prev_q  <= hit_in;
      if (busy_q && hit_in && !hit_prev_q && (hit_cnt_q != CNT_MAX))
        hit_cnt_q <= hit_cnt_q + 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sreg_q    <= pattern_in;
            hit_cnt_q <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            bit_out_q   <= sreg_q[WORD_W-1];
            sreg_q      <= sreg_q << 1;
            bit_valid_q <= 1'b1;
            idx_q       <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              drain_q <= '0;
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (tick) begin
            drain_q <= drain_q + 1'b1;
            if (drain_q == DRN_LAST) begin
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          led_q   <= (hit_cnt_q != '0);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hit_count = hit_cnt_q;
  assign led       = led_q;

endmodule

// File: tb/tb_sequence_feed_controller.sv
// Bench for sequence_feed_controller: default-rate instance driven through an
// overlapping "1011" detector model, plus a slow instance for hit saturation.
module tb_sequence_feed_controller;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] hits;
    logic       led;
  } vec_t;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic [7:0] pattern = '0;
  logic       start   = 1'b0;
  logic       bit_out, bit_valid, hit_in, busy, done, led;
  logic [3:0] hit_count;

  logic [7:0] pattern_s = '0;
  logic       start_s   = 1'b0;
  logic       hit_s     = 1'b0;
  logic       bit_out_s, bit_valid_s, busy_s, done_s, led_s;
  logic [3:0] hit_count_s;

  logic [3:0] det_hist = '0;
  logic       det_hit  = 1'b0;
  logic       det_clr  = 1'b0;
  logic       frc_en   = 1'b0;
  logic       frc_val  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sequence_feed_controller u_dut (
    .sys_clk_in (clk),
    .reset      (rst_n),
    .pattern_in (pattern),
    .start      (start),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .hit_in     (hit_in),
    .busy       (busy),
    .done       (done),
    .hit_count  (hit_count),
    .led        (led)
  );

  // DIV = 8 so a run is long enough to reach counter saturation.
  sequence_feed_controller #(.refreshHz(28'd125_0000)) u_slow (
    .sys_clk_in (clk),
    .reset      (rst_n),
    .pattern_in (pattern_s),
    .start      (start_s),
    .bit_out    (bit_out_s),
    .bit_valid  (bit_valid_s),
    .hit_in     (hit_s),
    .busy       (busy_s),
    .done       (done_s),
    .hit_count  (hit_count_s),
    .led        (led_s)
  );

  // Behavioural overlapping "1011" detector; level output held until the next bit.
  always @(negedge clk) begin
    if (!rst_n || det_clr) begin
      det_hist = '0;
      det_hit  = 1'b0;
    end else if (bit_valid) begin
      det_hist = {det_hist[2:0], bit_out};
      det_hit  = (det_hist == 4'b1011);
    end
  end

  assign hit_in = frc_en ? frc_val : det_hit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_det();
    det_clr = 1'b1;
    step();
    det_clr = 1'b0;
  endtask

  // Follows a run from one cycle after its start edge until done (bounded).
  task automatic watch(output logic [7:0] bits, output int nbits,
                       output int done_cyc, output int spacing_err);
    bits = '0; nbits = 0; done_cyc = -1; spacing_err = 0;
    for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
      step();
      if (bit_valid) begin
        bits = {bits[6:0], bit_out};
        nbits++;
        if (c != 2 * nbits) spacing_err++;
      end
      if (done) done_cyc = c;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] pat,
                               input logic [3:0] eh, input logic el);
    logic [7:0] bits;
    int nb, dc, se;
    pattern = pat;
    start   = 1'b1;
    step();
    start = 1'b0;
    watch(bits, nb, dc, se);
    chk({tag, "_bits"}, bits, pat);
    chk({tag, "_nbits"}, nb, 8);
    chk({tag, "_spacing"}, se, 0);
    chk({tag, "_done_cyc"}, dc, 21);
    chk({tag, "_hits"}, hit_count, eh);
    chk({tag, "_led"}, led, el);
    step();
    chk({tag, "_after"}, {done, busy, hit_count, led}, {1'b0, 1'b0, eh, el});
  endtask

  // mode 0: 20 one-cycle hit pulses; mode 1: hit raised once and held.
  task automatic slow_run(input string tag, input logic [7:0] pat, input int mode,
                          input logic [3:0] eh, input logic el);
    logic [7:0] bits;
    int nb, dc, se;
    bits = '0; nb = 0; dc = -1; se = 0;
    pattern_s = pat;
    start_s   = 1'b1;
    step();
    start_s = 1'b0;
    for (int c = 1; c <= 200 && dc < 0; c++) begin
      if (mode == 0) hit_s = (c <= 40) ? c[0] : 1'b0;
      else           hit_s = (c >= 3);
      step();
      if (bit_valid_s) begin
        bits = {bits[6:0], bit_out_s};
        nb++;
        if (c != 8 * nb) se++;
      end
      if (done_s) dc = c;
    end
    hit_s = 1'b0;
    chk({tag, "_bits"}, bits, pat);
    chk({tag, "_spacing"}, se, 0);
    chk({tag, "_done_cyc"}, dc, 81);
    chk({tag, "_hits"}, hit_count_s, eh);
    chk({tag, "_led"}, led_s, el);
    step();
  endtask

  initial begin
    vec_t       tbl [6];
    logic [7:0] bits, pat;
    logic [3:0] m_hist;
    logic       m_level, match;
    int         nb, nd, dc, se, cnt;

    tbl[0] = '{8'hBB, 4'd2, 1'b1};
    tbl[1] = '{8'h00, 4'd0, 1'b0};
    tbl[2] = '{8'hB0, 4'd1, 1'b1};
    tbl[3] = '{8'h2D, 4'd1, 1'b1};
    tbl[4] = '{8'h5B, 4'd2, 1'b1};
    tbl[5] = '{8'hFF, 4'd0, 1'b0};

    #1 rst_n = 1'b0;
    #1;
    chk("reset_main", {bit_out, bit_valid, busy, done, hit_count, led}, 9'd0);
    chk("reset_slow", {bit_out_s, bit_valid_s, busy_s, done_s, hit_count_s, led_s}, 9'd0);
    #20 rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      clear_det();
      run_and_check($sformatf("tbl%0d", i), tbl[i].pat, tbl[i].hits, tbl[i].led);
    end

    // start held high across the run, pattern changed mid-run
    clear_det();
    pattern = 8'hBB;
    start   = 1'b1;
    step();
    bits = '0; nb = 0; nd = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c == 5) pattern = 8'hFF;
      step();
      if (bit_valid) begin
        bits = {bits[6:0], bit_out};
        nb++;
      end
      if (done) nd++;
      if (c == 21) begin
        chk("held_done_at_21", done, 1);
        chk("held_hits", hit_count, 2);
      end
      if (c == 22) chk("held_restart_busy", busy, 1);
    end
    start = 1'b0;
    chk("held_bits", bits, 8'hBB);
    chk("held_nbits", nb, 8);
    chk("held_one_done", nd, 1);
    watch(bits, nb, dc, se);
    chk("held_run2_bits", bits, 8'hFF);
    chk("held_run2_done_cyc", dc, 21);
    chk("held_run2_hits", hit_count, 0);
    chk("held_run2_led", led, 0);
    step();

    // reset pulled mid-run after the 4th bit
    clear_det();
    pattern = 8'hBB;
    start   = 1'b1;
    step();
    start = 1'b0;
    nb = 0; nd = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (bit_valid) nb++;
      if (done) nd++;
    end
    chk("abort_pre_nbits", nb, 4);
    chk("abort_pre_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {bit_out, bit_valid, busy, done, hit_count, led}, 9'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    #2 rst_n = 1'b1;
    step();
    run_and_check("restart", 8'hBB, 4'd2, 1'b1);

    // hit edge while idle
    frc_en  = 1'b1;
    frc_val = 1'b0;
    step();
    step();
    frc_val = 1'b1;
    step();
    step();
    step();
    chk("idle_hit_ignored", hit_count, 2);
    chk("idle_not_busy", busy, 0);
    frc_en  = 1'b0;
    frc_val = 1'b0;
    step();

    // saturation and level hold on the slow instance
    slow_run("sat", 8'hA5, 0, 4'd15, 1'b1);
    slow_run("level", 8'h3C, 1, 4'd1, 1'b1);

    // random patterns against a history-carrying reference model
    clear_det();
    m_hist  = '0;
    m_level = 1'b0;
    for (int r = 0; r < 20; r++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
      pat = 8'($urandom);
      cnt = 0;
      for (int b = 7; b >= 0; b--) begin
        m_hist = {m_hist[2:0], pat[b]};
        match  = (m_hist == 4'b1011);
        if (match && !m_level) cnt++;
        m_level = match;
      end
      if (cnt > 15) cnt = 15;
      run_and_check($sformatf("rnd%0d_%02h", r, pat), pat, 4'(cnt), cnt != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
